// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types, constants and helpers for the RAM write-port arbiter.
// Contents: arb_state_t FSM encoding, zero-fill bit value, grant-id width function.
package ram_arb_pkg;
   typedef enum logic {ARB_INIT, ARB_RUN} arb_state_t;
   localparam logic ZERO_FILL = 1'b0;
   function automatic int gid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ram_1r1w_wr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting the search at ptr.
// Ports: req (request vector), ptr (search start); grant (one-hot winner),
// idx (winner index), any (some request is present).
module rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int GID  = gid_width(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [GID-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [GID-1:0]  idx,
   output logic            any
);
   // Scan from the farthest offset back to ptr so the closest request wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req[GID'((int'(ptr) + i) % NREQ)]) begin
            idx = GID'((int'(ptr) + i) % NREQ);
            any = 1'b1;
         end
      grant = any ? (NREQ'(1) << idx) : '0;
   end
endmodule

// File: rtl/ram_1r1w_wr_arbiter.sv
// ram_1r1w_wr_arbiter: round-robin controller sharing one RAM write port among NREQ requesters.
// Optional zero-fill sweep after reset is compiled in with RAM_1R1W_WR_ARB_INIT_EN.
// Ports: clk; reset (synchronous, active-low); req_valid_i/req_addr_i/req_data_i
// per-requester write requests; req_ready_o one-hot acceptance; ram_we_o/ram_addr_o/
// ram_data_o registered RAM write port; grant_id_o last accepted requester;
// init_done_o high once requests can be accepted.
module ram_1r1w_wr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DEPTH = 64,
   parameter int INDEX = 6,
   parameter int WIDTH = 32,
   parameter int GID   = gid_width(NREQ)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*INDEX-1:0] req_addr_i,
   input  logic [NREQ*WIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]       req_ready_o,
   output logic                  ram_we_o,
   output logic [INDEX-1:0]      ram_addr_o,
   output logic [WIDTH-1:0]      ram_data_o,
   output logic [GID-1:0]        grant_id_o,
   output logic                  init_done_o
);
   if (DEPTH != (1 << INDEX)) begin : g_bad_depth
      $error("DEPTH must equal 2**INDEX");
   end
   logic [NREQ-1:0]  grant;
   logic [GID-1:0]   idx;
   logic [GID-1:0]   ptr;
   logic             any;
   logic             run;
   logic             sweep;
   logic             acc;
   logic [INDEX-1:0] sweep_addr;
   rr_arbiter #(.NREQ(NREQ), .GID(GID)) u_rr (
      .req  (req_valid_i),
      .ptr  (ptr),
      .grant(grant),
      .idx  (idx),
      .any  (any)
   );
`ifdef RAM_1R1W_WR_ARB_INIT_EN
   arb_state_t       state;
   arb_state_t       state_nx;
   logic [INDEX-1:0] cnt;
   always_ff @(posedge clk)
      if (!reset) begin
         state <= ARB_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= (state == ARB_INIT) ? cnt + 1'b1 : '0;
      end
   // The last sweep address is issued in the same cycle the FSM leaves INIT.
   always_comb begin
      state_nx = state;
      if (state == ARB_INIT && cnt == INDEX'(DEPTH - 1))
         state_nx = ARB_RUN;
   end
   assign sweep      = (state == ARB_INIT);
   assign sweep_addr = cnt;
`else
   assign sweep      = 1'b0;
   assign sweep_addr = '0;
`endif
   assign run         = ~sweep;
   assign acc         = run & any;
   assign req_ready_o = run ? grant : '0;
   assign init_done_o = run;
   always_ff @(posedge clk)
      if (!reset) begin
         ram_we_o   <= 1'b0;
         ram_addr_o <= '0;
         ram_data_o <= '0;
         grant_id_o <= '0;
         ptr        <= '0;
      end else begin
         ram_we_o <= sweep | acc;
         if (sweep) begin
            ram_addr_o <= sweep_addr;
            ram_data_o <= {WIDTH{ZERO_FILL}};
         end else if (acc) begin
            ram_addr_o <= req_addr_i[int'(idx)*INDEX +: INDEX];
            ram_data_o <= req_data_i[int'(idx)*WIDTH +: WIDTH];
            grant_id_o <= idx;
            ptr        <= (idx == GID'(NREQ - 1)) ? '0 : idx + 1'b1;
         end
      end
endmodule

// File: tb/tb_ram_1r1w_wr_arbiter.sv
// tb_ram_1r1w_wr_arbiter: directed and random checks of the RAM write-port arbiter.
module tb_ram_1r1w_wr_arbiter;
   localparam int NREQ  = 4;
   localparam int DEPTH = 64;
   localparam int INDEX = 6;
   localparam int WIDTH = 32;
   localparam int GID   = 2;
   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic [NREQ-1:0]       req_valid_i = '0;
   logic [NREQ*INDEX-1:0] req_addr_i = '0;
   logic [NREQ*WIDTH-1:0] req_data_i = '0;
   logic [NREQ-1:0]       req_ready_o;
   logic                  ram_we_o;
   logic [INDEX-1:0]      ram_addr_o;
   logic [WIDTH-1:0]      ram_data_o;
   logic [GID-1:0]        grant_id_o;
   logic                  init_done_o;
   ram_1r1w_wr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .GID(GID)) dut (
      .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
      .req_data_i(req_data_i), .req_ready_o(req_ready_o), .ram_we_o(ram_we_o),
      .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .grant_id_o(grant_id_o),
      .init_done_o(init_done_o)
   );
   always #5 clk = ~clk;
   int nchecks = 0;
   int nerr = 0;
   logic [NREQ-1:0]  val = '0;
   logic [INDEX-1:0] a [NREQ];
   logic [WIDTH-1:0] d [NREQ];
   int               mptr = 0;
   logic             exp_we = 1'b0;
   logic [INDEX-1:0] exp_addr = '0;
   logic [WIDTH-1:0] exp_data = '0;
   logic [GID-1:0]   exp_gid = '0;
   logic [WIDTH-1:0] mem_exp [DEPTH];
   logic [WIDTH-1:0] ram [DEPTH];
   bit               known [DEPTH];
   logic [NREQ-1:0]  last_ready = '0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   // Round-robin rule: first valid requester at or after the pointer, wrapping.
   function automatic int pick(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++)
         if (v[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
      return -1;
   endfunction
   task automatic drive();
      req_valid_i = val;
      for (int i = 0; i < NREQ; i++) begin
         req_addr_i[i*INDEX +: INDEX] = a[i];
         req_data_i[i*WIDTH +: WIDTH] = d[i];
      end
   endtask
   task automatic cycle();
      int k;
      drive();
      #1;
      k = pick(val);
      last_ready = req_ready_o;
      chk("ready", req_ready_o, (k < 0) ? 64'd0 : (64'd1 << k));
      @(posedge clk);
      #1;
      if (k >= 0) begin
         exp_we = 1'b1;
         exp_addr = a[k];
         exp_data = d[k];
         exp_gid = GID'(k);
         mptr = (k + 1) % NREQ;
         mem_exp[a[k]] = d[k];
         known[a[k]] = 1'b1;
         val[k] = 1'b0;
      end else exp_we = 1'b0;
      chk("we", ram_we_o, exp_we);
      chk("addr", ram_addr_o, exp_addr);
      chk("data", ram_data_o, exp_data);
      chk("gid", grant_id_o, exp_gid);
      chk("init_done", init_done_o, 1'b1);
      if (ram_we_o) ram[ram_addr_o] = ram_data_o;
   endtask
   task automatic do_reset(input int n);
      val = '0;
      drive();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("rst_we", ram_we_o, 1'b0);
      chk("rst_addr", ram_addr_o, 0);
      chk("rst_data", ram_data_o, 0);
      chk("rst_gid", grant_id_o, 0);
      chk("rst_ready", req_ready_o, 0);
      mptr = 0;
      exp_we = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_gid = '0;
`ifdef RAM_1R1W_WR_ARB_INIT_EN
      chk("rst_init_done", init_done_o, 1'b0);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk("sweep_we", ram_we_o, 1'b1);
         chk("sweep_addr", ram_addr_o, i);
         chk("sweep_data", ram_data_o, 0);
         if (ram_we_o) ram[ram_addr_o] = ram_data_o;
         mem_exp[i] = '0;
         known[i] = 1'b1;
         exp_addr = INDEX'(i);
      end
      if (n == DEPTH) begin
         @(posedge clk);
         #1;
         chk("init_done_after_sweep", init_done_o, 1'b1);
         chk("we_after_sweep", ram_we_o, 1'b0);
      end
`else
      if (n >= 0) chk("init_done_tied", init_done_o, 1'b1);
`endif
   endtask
   initial begin
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         a[i] = '0;
         d[i] = '0;
      end
      do_reset(20);
      do_reset(DEPTH);
`ifdef RAM_1R1W_WR_ARB_INIT_EN
      for (int i = 0; i < DEPTH; i++) chk("zero_fill", ram[i], 0);
`else
      val = 4'b0001; a[0] = 6'd7; d[0] = 32'hA5A5_0001;
      cycle();
      chk("first_accept", last_ready, 4'b0001);
      do_reset(0);
`endif
      val = 4'b0100; a[2] = 6'd5; d[2] = 32'hDEAD_BEEF;
      cycle();
      chk("single_ready", last_ready, 4'b0100);
      chk("single_addr", ram_addr_o, 5);
      chk("single_data", ram_data_o, 32'hDEAD_BEEF);
      chk("single_gid", grant_id_o, 2);
      do_reset(DEPTH);
      for (int i = 0; i < 8; i++) begin
         for (int r = 0; r < NREQ; r++) if (!val[r]) begin
            a[r] = INDEX'(16 + r);
            d[r] = $urandom;
         end
         val = 4'b1111;
         cycle();
         chk("rr_order", grant_id_o, i % NREQ);
         chk("rr_onehot", $countones(last_ready), 1);
      end
      do_reset(DEPTH);
      val = 4'b0010; a[1] = 6'd1; d[1] = 32'h0;
      cycle();
      val = 4'b1010; a[1] = 6'd9; d[1] = 32'h11; a[3] = 6'd9; d[3] = 32'h33;
      cycle();
      chk("same_first", grant_id_o, 3);
      cycle();
      chk("same_second", grant_id_o, 1);
      cycle();
      chk("same_ram", ram[9], 32'h11);
      val = 4'b1111;
      for (int r = 0; r < NREQ; r++) begin
         a[r] = INDEX'(32 + r);
         d[r] = $urandom;
      end
      cycle();
      cycle();
      do_reset(DEPTH);
      val = 4'b1111;
      cycle();
      chk("post_reset_gid", grant_id_o, 0);
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < NREQ; r++)
            if (!val[r] && $urandom_range(0, 2) == 0) begin
               val[r] = 1'b1;
               a[r] = INDEX'($urandom_range(0, 15));
               d[r] = $urandom;
            end
         cycle();
      end
      val = '0;
      cycle();
      cycle();
      for (int i = 0; i < DEPTH; i++)
         if (known[i]) chk("ram_final", ram[i], mem_exp[i]);
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end
endmodule
